seg_display_arbiter: RTL
========================

Name: seg_display_arbiter

Overview:
- Shares the NUMCELLS-digit seven-segment display between NREQ independent sources, such as the elapsed-time path and a status/message source.
- Each source presents pre-decoded per-cell segment bytes. The arbiter grants exactly one owner at a time and inserts a timed blank gap between owners.
- Enforces a minimum hold time before a contending requester can preempt the current owner.
- Sits between the cell-value producers and the cell-scanning driver. Its output feeds that driver's cell-value input directly.

Parameters:
- NUMCELLS, 4, number of display cells.
- CELLW, 8, bits per decoded cell value.
- NREQ, 2, number of requesters (2..8).
- TICKDIV, 12000, clock cycles per tick (1 ms at 12 MHz).
- MINHOLD, 500, ticks an owner keeps the display before preemption is allowed (>=1).
- BLANKTICKS, 20, ticks of blank output between owners (0 = no gap).
- BLANKCODE, 8'h00, per-cell value driven while blank (all segments off).

Ports:
- clock, in, 1, system clock (12 MHz).
- rst, in, 1, synchronous active-high reset.
- req, in, NREQ, level request per source. Held high while the source wants the display.
- cellval_in, in, NREQ*NUMCELLS*CELLW, concatenated cell values. Source k occupies slice [k*NUMCELLS*CELLW +: NUMCELLS*CELLW].
- grant, out, NREQ, one-hot current owner. All zeros when there is no owner.
- owner, out, clog2(NREQ) (min 1), index of the current or last owner.
- busy, out, 1, high in BLANK or OWN.
- cellval_out, out, NUMCELLS*CELLW, value sent to the display driver.

Behaviour:
- Reset values:
  - All state is updated on the rising edge of clock.
  - On rst=1 the state becomes IDLE, grant=0, owner=0, busy=0, and cellval_out=BLANKCODE replicated to all cells.
  - The round-robin last-winner pointer resets to NREQ-1, so source 0 has priority first.
  - The prescaler and all counters reset to 0.
  - rst takes precedence over all other inputs in the same cycle and aborts any state immediately.
- Tick prescaler:
  - The counter runs 0..TICKDIV-1 and produces a one-cycle tick pulse on wrap.
  - It is cleared on every state transition, so state durations are exact multiples of TICKDIV.
- Arbitration:
  - Round-robin, starting at last-winner+1 modulo NREQ.
  - The winner is latched on the transition into BLANK, and the last-winner pointer is updated at the same time.
- State IDLE:
  - Outputs are blank and grant=0.
  - If any req is high, latch the winner and go to BLANK. If BLANKTICKS=0, go directly to OWN.
- State BLANK:
  - Outputs are blank and grant=0.
  - The state lasts exactly BLANKTICKS*TICKDIV cycles.
  - At expiry:
    - if the latched winner's req is still high, go to OWN;
    - otherwise re-arbitrate over the current req; on a new winner restart BLANK, and if there is none go to IDLE.
- State OWN:
  - grant has the owner bit set and owner=index.
  - cellval_out is a registered copy of the owner's slice, so an input change appears one cycle later.
  - The hold counter counts ticks and saturates at MINHOLD.
  - Exit conditions:
    - If the owner's req drops, leave next cycle regardless of the hold count. Go to BLANK if another req is high, else IDLE.
    - If the hold count equals MINHOLD and any other req is high, preempt by going to BLANK with the round-robin winner.
    - If only the owner requests, it keeps the display indefinitely.
- Outputs and flags:
  - On the cycle OWN is left, grant drops and cellval_out returns to BLANKCODE.
  - busy = (state != IDLE).
- Simultaneous events:
  - If the owner drops in the same cycle the hold count matches, the drop path applies. The result is identical: a winner is chosen among the others.
  - A req pulse that is shorter than one cycle, or that falls low before it is sampled, is ignored.
- Width rules:
  - The hold counter is clog2(MINHOLD+1) bits.
  - The blank counter is clog2(BLANKTICKS+1) bits.
  - The prescaler is clog2(TICKDIV) bits.
  - No counter wraps.

Decomposition:
- Package seg_arb_pkg:
  - state enum {IDLE, BLANK, OWN};
  - BLANKCODE default;
  - a helper function for the round-robin one-hot select.
- One sub-module, seg_tick_gen: the prescaler with parameter TICKDIV, inputs clock, rst and clr, and output tick.

Test Plan:
Bench parameters: TICKDIV=4, MINHOLD=3, BLANKTICKS=2, NREQ=2, NUMCELLS=4; cycle 0 is the first edge after rst is released.
- Reset: rst=1 for 2 cycles with req=11 → grant=00, busy=0, owner=0, cellval_out=32'h00000000 throughout reset.
- Single request: req=01 from cycle 0 → busy=1 from cycle 1; grant=01 first at cycle 9; cellval_out=slice0 (e.g. 32'h3F065B4F) at cycle 9. A slice0 change appears one cycle later.
- Preemption: source 0 owns from cycle 9 and req=11 is held → grant=00 at cycle 21 (12 cycles of hold) → grant=10 at cycle 29.
- Tie from IDLE and rotation: req=11 from reset → source 0 wins first. After source 0 drops, source 1 is granted.
- Early release: req=01, then req drops 2 cycles into OWN with no other requester → state IDLE next cycle; grant=00; busy=0; blank output.
- Reset mid-BLANK: rst=1 at cycle 4 of BLANK → next cycle shows IDLE reset values. Re-request then gives the full 8-cycle blank with no residual count.

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared types, defaults and round-robin helpers for the display arbiter.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    OWN   = 2'd2
  } arb_state_e;

  // All segments off.
  localparam logic [7:0] BLANKCODE_DEF = 8'h00;

  // Upper bound on requesters; helpers work on vectors of this width.
  localparam int MAXREQ = 8;

  // One-hot pick of the first active request after 'last', wrapping modulo n.
  function automatic logic [7:0] rr_onehot(input logic [7:0] req,
                                           input logic [2:0] last,
                                           input int         n);
    logic [7:0] sel;
    logic [2:0] idx;
    sel = 8'h00;
    for (int i = 1; i <= MAXREQ; i++) begin
      if (i <= n) begin
        idx = 3'((int'(last) + i) % n);
        if ((sel == 8'h00) && req[idx]) begin
          sel[idx] = 1'b1;
        end
      end
    end
    return sel;
  endfunction

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAXREQ; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Tick prescaler: counts 0..TICKDIV-1 and pulses tick for one cycle on wrap.
// clr restarts the count so callers get exact multiples of TICKDIV.
module seg_tick_gen #(
  parameter int  TICKDIV = 12000,
  localparam int TW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [TW-1:0] cnt_r;

  assign tick = (cnt_r == TW'(TICKDIV - 1));

  // Prescaler counter with reset and clear, wrapping at TICKDIV-1.
  always_ff @(posedge clock) begin
    if (rst || clr) begin
      cnt_r <= {TW{1'b0}};
    end else if (tick) begin
      cnt_r <= {TW{1'b0}};
    end else begin
      cnt_r <= cnt_r + TW'(1);
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares a multi-cell seven-segment display between NREQ sources: round-robin
// ownership, a minimum hold before preemption and a blank gap between owners.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int               NUMCELLS   = 4,
  parameter int               CELLW      = 8,
  parameter int               NREQ       = 2,
  parameter int               TICKDIV    = 12000,
  parameter int               MINHOLD    = 500,
  parameter int               BLANKTICKS = 20,
  parameter logic [CELLW-1:0] BLANKCODE  = CELLW'(BLANKCODE_DEF),
  localparam int              OW         = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int              SLW        = NUMCELLS * CELLW
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SLW-1:0]  cellval_in,
  output logic [NREQ-1:0]      grant,
  output logic [OW-1:0]        owner,
  output logic                 busy,
  output logic [SLW-1:0]       cellval_out
);

  localparam int HW = $clog2(MINHOLD + 1);
  localparam int BW = (BLANKTICKS > 0) ? $clog2(BLANKTICKS + 1) : 1;
  // With no blank gap a handover goes straight to the next owner.
  localparam arb_state_e GAP_ST = (BLANKTICKS == 0) ? OWN : BLANK;
  localparam logic [SLW-1:0] BLANK_ALL = {NUMCELLS{BLANKCODE}};
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e      state_r, state_s;
  logic [OW-1:0]   winner_r, last_r;
  logic [HW-1:0]   hold_r;
  logic [BW-1:0]   blank_r;
  logic [NREQ-1:0] grant_r;
  logic            busy_r;
  logic [SLW-1:0]  cellval_r;

  logic            tick_s, clr_s, latch_s;
  logic [7:0]      rr_oh_s;
  logic            rr_any_s;
  logic [OW-1:0]   rr_idx_s, nxt_idx_s;
  logic            others_s, hold_hit_s, blank_done_s, own_req_s;

  seg_tick_gen #(.TICKDIV(TICKDIV)) u_tick (
    .clock (clock),
    .rst   (rst),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  assign rr_oh_s      = rr_onehot(8'(req), 3'(last_r), NREQ);
  assign rr_any_s     = |rr_oh_s;
  assign rr_idx_s     = OW'(onehot_idx(rr_oh_s));
  assign own_req_s    = req[winner_r];
  assign others_s     = |(req & ~(ONE_HOT0 << winner_r));
  // Hold is reached either already, or by the tick being counted this cycle.
  assign hold_hit_s   = (hold_r == HW'(MINHOLD)) ||
                        (tick_s && (hold_r == HW'(MINHOLD - 1)));
  assign blank_done_s = tick_s && (blank_r == BW'(BLANKTICKS - 1));
  // Any state change or winner relatch restarts the prescaler.
  assign clr_s        = (state_s != state_r) || latch_s;

  // Next-state and winner-latch decision.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rr_any_s) begin
          latch_s = 1'b1;
          state_s = GAP_ST;
        end else begin
          state_s = IDLE;
        end
      end
      BLANK: begin
        if (!blank_done_s) begin
          state_s = BLANK;
        end else if (own_req_s) begin
          state_s = OWN;
        end else if (rr_any_s) begin
          latch_s = 1'b1;
          state_s = BLANK;
        end else begin
          state_s = IDLE;
        end
      end
      OWN: begin
        if (!own_req_s) begin
          if (rr_any_s) begin
            latch_s = 1'b1;
            state_s = GAP_ST;
          end else begin
            state_s = IDLE;
          end
        end else if (hold_hit_s && others_s) begin
          latch_s = 1'b1;
          state_s = GAP_ST;
        end else begin
          state_s = OWN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Owner index that will be in force after this edge.
  always_comb begin
    nxt_idx_s = winner_r;
    if (latch_s) begin
      nxt_idx_s = rr_idx_s;
    end else begin
      nxt_idx_s = winner_r;
    end
  end

  // State, winner, last-winner pointer and tick counters.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r  <= IDLE;
      winner_r <= {OW{1'b0}};
      last_r   <= OW'(NREQ - 1);
      hold_r   <= {HW{1'b0}};
      blank_r  <= {BW{1'b0}};
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        winner_r <= rr_idx_s;
        last_r   <= rr_idx_s;
      end
      if (clr_s || (state_r != OWN)) begin
        hold_r <= {HW{1'b0}};
      end else if (tick_s && (hold_r != HW'(MINHOLD))) begin
        hold_r <= hold_r + HW'(1);
      end
      if (clr_s || (state_r != BLANK)) begin
        blank_r <= {BW{1'b0}};
      end else if (tick_s && (blank_r != BW'(BLANKTICKS))) begin
        blank_r <= blank_r + BW'(1);
      end
    end
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge clock) begin
    if (rst) begin
      grant_r   <= {NREQ{1'b0}};
      busy_r    <= 1'b0;
      cellval_r <= BLANK_ALL;
    end else begin
      busy_r <= (state_s != IDLE);
      if (state_s == OWN) begin
        grant_r   <= ONE_HOT0 << nxt_idx_s;
        cellval_r <= cellval_in[int'(nxt_idx_s) * SLW +: SLW];
      end else begin
        grant_r   <= {NREQ{1'b0}};
        cellval_r <= BLANK_ALL;
      end
    end
  end

  assign grant       = grant_r;
  assign owner       = winner_r;
  assign busy        = busy_r;
  assign cellval_out = cellval_r;

endmodule
